// File: rtl/intake_pkg.sv
// Shared types and constants for the front-panel intake sequencer.
package intake_pkg;

  localparam int MAX_PAIRS  = 4;
  localparam int SLOT_IDX_W = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAP_A    = 3'd1,
    CAP_B    = 3'd2,
    CAP_C    = 3'd3,
    CAP_D    = 3'd4,
    PLAYBACK = 3'd5
  } state_t;

  // One stored entry: X nibble in the upper half, Y nibble in the lower half.
  typedef logic [7:0] slot_t;

  // (0,0) is the end-of-entry / clear marker.
  function automatic logic is_zero_pair(input logic [3:0] px, input logic [3:0] py);
    return (px == 4'd0) && (py == 4'd0);
  endfunction

  // Advance the playback index, wrapping over the stored slots only.
  function automatic logic [SLOT_IDX_W-1:0] next_scan_idx(
    input logic [SLOT_IDX_W-1:0] idx,
    input logic [2:0]            count
  );
    logic [2:0] last;
    last = count - 3'd1;
    if ({1'b0, idx} == last) begin
      return 2'd0;
    end else begin
      return idx + 2'd1;
    end
  endfunction

endpackage

// File: rtl/intake_sequencer_scan_timer.sv
// Modulo-DIV counter; tick is high for the single clock the count sits at DIV-1.
module scan_timer #(
  parameter int DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] count_r;

  assign tick = enable && !clear && (count_r == TERM);

  // Count while enabled, wrap at the terminal count, clear on request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= tick ? '0 : count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/intake_sequencer.sv
// Front-panel intake: captures up to four (X,Y) pairs on enter presses,
// then cycles through them for the hex displays until cleared by (0,0).
module intake_sequencer
  import intake_pkg::*;
#(
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       enter,
  output logic [2:0] state,
  output logic [2:0] pair_count,
  output logic       done,
  output logic [1:0] view_idx,
  output logic [3:0] view_x,
  output logic [3:0] view_y
);

  state_t                  state_r, state_nx_s;
  logic                    enter_q_r;
  logic [2:0]              pair_count_r, pair_count_nx_s;
  slot_t                   slots_r    [MAX_PAIRS];
  slot_t                   slots_nx_s [MAX_PAIRS];
  logic [SLOT_IDX_W-1:0]   view_idx_r, view_idx_nx_s;
  logic [3:0]              view_x_r, view_y_r;
  logic                    done_r;
  logic                    accept_s;
  logic                    zero_s;
  logic                    tick_s;
  logic                    scan_clear_s;
  logic [2:0]              cap_off_s;
  logic [SLOT_IDX_W-1:0]   cap_idx_s;
  logic [2:0]              last_s;

  assign accept_s     = enter && !enter_q_r;
  assign zero_s       = is_zero_pair(x, y);
  assign cap_off_s    = state_r - CAP_A;
  assign cap_idx_s    = cap_off_s[1:0];
  assign last_s       = pair_count_nx_s - 3'd1;
  // Hold the timer at zero outside playback and whenever playback is left.
  assign scan_clear_s = (state_r != PLAYBACK) || (state_nx_s != PLAYBACK);

  scan_timer #(.DIV(SCAN_DIV)) u_scan_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (scan_clear_s),
    .enable (state_r == PLAYBACK),
    .tick   (tick_s)
  );

  // Next state, slot store, pair count and presented index.
  always_comb begin
    state_nx_s      = state_r;
    pair_count_nx_s = pair_count_r;
    slots_nx_s      = slots_r;
    view_idx_nx_s   = view_idx_r;
    case (state_r)
      IDLE: begin
        state_nx_s = CAP_A;
      end
      CAP_A, CAP_B, CAP_C, CAP_D: begin
        if (accept_s) begin
          if (zero_s) begin
            // An empty entry is ignored; otherwise (0,0) closes the entry.
            if (pair_count_r == 3'd0) begin
              state_nx_s = state_r;
            end else begin
              state_nx_s = PLAYBACK;
            end
          end else begin
            slots_nx_s[cap_idx_s] = {x, y};
            if (pair_count_r == 3'd4) begin
              pair_count_nx_s = pair_count_r;
            end else begin
              pair_count_nx_s = pair_count_r + 3'd1;
            end
            if (state_r == CAP_D) begin
              state_nx_s = PLAYBACK;
            end else begin
              state_nx_s = state_t'(state_r + 3'd1);
            end
          end
        end else begin
          state_nx_s = state_r;
        end
      end
      PLAYBACK: begin
        if (accept_s && zero_s) begin
          for (int i = 0; i < MAX_PAIRS; i++) begin
            slots_nx_s[i] = 8'd0;
          end
          pair_count_nx_s = 3'd0;
          state_nx_s      = CAP_A;
        end else begin
          state_nx_s = PLAYBACK;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase

    if (state_nx_s == PLAYBACK) begin
      if (state_r != PLAYBACK) begin
        view_idx_nx_s = 2'd0;
      end else if (tick_s) begin
        view_idx_nx_s = next_scan_idx(view_idx_r, pair_count_r);
      end else begin
        view_idx_nx_s = view_idx_r;
      end
    end else begin
      // Live echo of the most recently written slot.
      if (pair_count_nx_s == 3'd0) begin
        view_idx_nx_s = 2'd0;
      end else begin
        view_idx_nx_s = last_s[1:0];
      end
    end
  end

  // State, store and registered display outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      enter_q_r    <= 1'b0;
      pair_count_r <= 3'd0;
      view_idx_r   <= 2'd0;
      view_x_r     <= 4'd0;
      view_y_r     <= 4'd0;
      done_r       <= 1'b0;
      for (int i = 0; i < MAX_PAIRS; i++) begin
        slots_r[i] <= 8'd0;
      end
    end else begin
      state_r      <= state_nx_s;
      enter_q_r    <= enter;
      pair_count_r <= pair_count_nx_s;
      view_idx_r   <= view_idx_nx_s;
      view_x_r     <= slots_nx_s[view_idx_nx_s][7:4];
      view_y_r     <= slots_nx_s[view_idx_nx_s][3:0];
      done_r       <= (state_nx_s == PLAYBACK);
      for (int i = 0; i < MAX_PAIRS; i++) begin
        slots_r[i] <= slots_nx_s[i];
      end
    end
  end

  assign state      = state_r;
  assign pair_count = pair_count_r;
  assign done       = done_r;
  assign view_idx   = view_idx_r;
  assign view_x     = view_x_r;
  assign view_y     = view_y_r;

endmodule

// File: tb/tb_intake_sequencer.sv
// Directed bench for intake_sequencer with a scoreboard of expected playback views.
module tb_intake_sequencer;

  logic       clock;
  logic       reset;
  logic [3:0] x;
  logic [3:0] y;
  logic       enter;
  logic [2:0] state;
  logic [2:0] pair_count;
  logic       done;
  logic [1:0] view_idx;
  logic [3:0] view_x;
  logic [3:0] view_y;

  int pass_cnt;
  int total_cnt;

  logic [7:0] model_q [$];
  logic [7:0] exp_q   [$];

  intake_sequencer #(.SCAN_DIV(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .enter      (enter),
    .state      (state),
    .pair_count (pair_count),
    .done       (done),
    .view_idx   (view_idx),
    .view_x     (view_x),
    .view_y     (view_y)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One press: enter high for one clock, returns at the negedge after the sampling edge.
  task automatic press(input logic [3:0] px, input logic [3:0] py);
    @(negedge clock);
    x = px;
    y = py;
    enter = 1'b1;
    @(negedge clock);
    enter = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [2:0] st, input logic [2:0] pc, input logic dn);
    check({tag, "_state"}, state, st);
    check({tag, "_count"}, pair_count, pc);
    check({tag, "_done"}, done, dn);
  endtask

  // Queue nblocks expected views from the stored-pair model, then compare each clock.
  task automatic scan_check(input int nblocks);
    logic [7:0] e;
    for (int b = 0; b < nblocks; b++) exp_q.push_back(model_q[b % model_q.size()]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int c = 0; c < 4; c++) begin
        check("scan_view", {view_x, view_y}, e);
        @(negedge clock);
      end
    end
  endtask

  initial begin
    logic [1:0] prev;
    logic       found;
    pass_cnt  = 0;
    total_cnt = 0;
    reset = 1'b1;
    enter = 1'b0;
    x = 4'd0;
    y = 4'd0;

    // Reset values, then one clock to CAP_A.
    repeat (2) @(negedge clock);
    check_status("reset", 3'd0, 3'd0, 1'b0);
    check("reset_view", {view_idx, view_x, view_y}, 10'd0);
    reset = 1'b0;
    @(negedge clock);
    check_status("first_clk", 3'd1, 3'd0, 1'b0);
    check("first_clk_view", {view_x, view_y}, 8'h00);

    // Two pairs then (0,0): playback alternates over the two stored slots.
    press(4'h3, 4'h5); model_q.push_back(8'h35);
    check_status("cap1", 3'd2, 3'd1, 1'b0);
    check("cap1_echo", {view_x, view_y}, 8'h35);
    press(4'hA, 4'h1); model_q.push_back(8'hA1);
    check_status("cap2", 3'd3, 3'd2, 1'b0);
    check("cap2_echo", {view_idx, view_x, view_y}, {2'd1, 8'hA1});
    press(4'h0, 4'h0);
    check_status("play2", 3'd5, 3'd2, 1'b1);
    scan_check(3);

    // (0,0) in playback clears back to CAP_A.
    press(4'h0, 4'h0); model_q.delete();
    check_status("clear1", 3'd1, 3'd0, 1'b0);
    check("clear1_view", {view_x, view_y}, 8'h00);

    // Four pairs go straight to playback; a non-zero press there is ignored.
    press(4'h1, 4'h2); model_q.push_back(8'h12);
    press(4'h3, 4'h4); model_q.push_back(8'h34);
    press(4'h5, 4'h6); model_q.push_back(8'h56);
    press(4'h7, 4'h8); model_q.push_back(8'h78);
    check_status("play4", 3'd5, 3'd4, 1'b1);
    check("play4_view", {view_idx, view_x, view_y}, {2'd0, 8'h12});
    press(4'h9, 4'h9);
    check_status("ignore99", 3'd5, 3'd4, 1'b1);
    prev  = view_idx;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (prev == 2'd3 && view_idx == 2'd0) found = 1'b1;
      else prev = view_idx;
    end
    check("wrap_seen", found, 1'b1);
    scan_check(5);
    press(4'h0, 4'h0); model_q.delete();
    check_status("clear2", 3'd1, 3'd0, 1'b0);

    // Held enter yields exactly one capture.
    @(negedge clock);
    x = 4'h6;
    y = 4'h6;
    enter = 1'b1;
    repeat (20) @(negedge clock);
    enter = 1'b0;
    @(negedge clock);
    check_status("held", 3'd2, 3'd1, 1'b0);
    check("held_echo", {view_x, view_y}, 8'h66);
    press(4'h0, 4'h0); model_q.push_back(8'h66);
    check_status("play1", 3'd5, 3'd1, 1'b1);
    scan_check(2);
    press(4'h0, 4'h0); model_q.delete();
    check_status("clear3", 3'd1, 3'd0, 1'b0);

    // (0,0) while empty stays in CAP_A.
    press(4'h0, 4'h0);
    check_status("empty_zero", 3'd1, 3'd0, 1'b0);

    // Asynchronous reset mid-playback, between clock edges.
    press(4'h3, 4'h5);
    press(4'h0, 4'h0);
    check_status("pre_rst", 3'd5, 3'd1, 1'b1);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_status("async_rst", 3'd0, 3'd0, 1'b0);
    check("async_rst_view", {view_idx, view_x, view_y}, 10'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_status("post_rst", 3'd1, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
